edge_detect_multi_amisha: RTL and testbench

Parametrised multi-channel successor to the single-level Moore edge detector. Each channel has an optional input synchroniser, a debounce filter and a Moore-style edge FSM. Each channel produces registered one-cycle tick pulses for rising, falling or both edges, selected at run time per channel. It sits between asynchronous/bouncy inputs (buttons, switches, external strobes) and the synchronous control logic.

---
 rtl/edge_detect_multi_amisha_pkg.sv | 22 ++
 rtl/edge_detect_multi_amisha_chan.sv | 118 +++++++++++
 rtl/edge_detect_multi_amisha.sv | 65 ++++++
 tb/tb_edge_detect_multi_amisha.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detect_multi_amisha_pkg.sv
// Shared types for the multi-channel debounced edge detector: FSM state
// encoding, per-channel mode codes and a state-to-level helper.
package edge_detect_pkg_amisha;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    RISE = 2'd1,
    ONE  = 2'd2,
    FALL = 2'd3
  } state_e;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Filtered level carried by each state; RISE/FALL already show the new level.
  function automatic logic state_level(input state_e s);
    return (s == RISE) || (s == ONE);
  endfunction

endpackage

// File: rtl/edge_detect_multi_amisha_chan.sv
// One channel: optional synchroniser, debounce counter, Moore edge FSM and
// registered rise/fall/level outputs.
module edge_detect_chan_amisha
  import edge_detect_pkg_amisha::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_level,
  input  logic [1:0] i_mode,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_tick,
  output logic       o_level_filt,
  output logic       o_tick_next
);

  logic             w_s;
  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_rise_en;
  logic             w_fall_en;
  logic             w_rise_next;
  logic             w_fall_next;
  logic             r_rise;
  logic             r_fall;
  logic             r_level_filt;

  if (SYNC_STAGES == 0) begin : g_no_sync
    assign w_s = i_level;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= i_level;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          r_sync[k] <= r_sync[k-1];
        end
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
  end

  always_comb begin
    w_rise_en = 1'b0;
    w_fall_en = 1'b0;
    unique case (i_mode)
      MODE_OFF:  ;
      MODE_RISE: w_rise_en = 1'b1;
      MODE_FALL: w_fall_en = 1'b1;
      MODE_BOTH: begin
        w_rise_en = 1'b1;
        w_fall_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter runs only while the synchronised input disagrees with the
  // filtered level; reaching STABLE_CYCLES-1 on a disagreeing cycle accepts.
  always_comb begin
    w_accept     = 1'b0;
    w_cnt_next   = '0;
    w_state_next = r_state;
    if (w_s != state_level(r_state)) begin
      if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
        w_accept = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
    unique case (r_state)
      ZERO: if (w_accept) w_state_next = RISE;
      RISE: w_state_next = w_accept ? FALL : ONE;
      ONE:  if (w_accept) w_state_next = FALL;
      FALL: w_state_next = w_accept ? RISE : ZERO;
      default: w_state_next = ZERO;
    endcase
  end

  // RISE/FALL are only ever entered on an acceptance edge, so mode changes
  // alone can never produce a pulse.
  assign w_rise_next = (w_state_next == RISE) && w_rise_en;
  assign w_fall_next = (w_state_next == FALL) && w_fall_en;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ZERO;
      r_cnt        <= '0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_level_filt <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_rise       <= w_rise_next;
      r_fall       <= w_fall_next;
      r_level_filt <= state_level(w_state_next);
    end
  end

  assign o_rise       = r_rise;
  assign o_fall       = r_fall;
  assign o_tick       = r_rise | r_fall;
  assign o_level_filt = r_level_filt;
  assign o_tick_next  = w_rise_next | w_fall_next;

endmodule

// File: rtl/edge_detect_multi_amisha.sv
// Multi-channel debounced edge detector: replicates the channel block and
// registers a combined tick flag aligned with the per-channel ticks.
module edge_detect_multi_amisha
  import edge_detect_pkg_amisha::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  clk_amisha,
  input  logic                  reset_amisha,
  input  logic [CHANNELS-1:0]   level_amisha,
  input  logic [2*CHANNELS-1:0] mode_amisha,
  output logic [CHANNELS-1:0]   tick_amisha,
  output logic [CHANNELS-1:0]   rise_amisha,
  output logic [CHANNELS-1:0]   fall_amisha,
  output logic [CHANNELS-1:0]   level_filt_amisha,
  output logic                  any_tick_amisha
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $fatal(1, "edge_detect_multi_amisha: CHANNELS out of range");
  end
  if (SYNC_STAGES > 4) begin : g_bad_sync
    $fatal(1, "edge_detect_multi_amisha: SYNC_STAGES out of range");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || (STABLE_CYCLES >> CNT_W) != 0)
  begin : g_bad_stable
    $fatal(1, "edge_detect_multi_amisha: STABLE_CYCLES does not fit CNT_W");
  end

  logic [CHANNELS-1:0] w_tick_next;
  logic                r_any_tick;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_detect_chan_amisha #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_chan (
      .i_clk        (clk_amisha),
      .i_rst_n      (reset_amisha),
      .i_level      (level_amisha[i]),
      .i_mode       (mode_amisha[2*i +: 2]),
      .o_rise       (rise_amisha[i]),
      .o_fall       (fall_amisha[i]),
      .o_tick       (tick_amisha[i]),
      .o_level_filt (level_filt_amisha[i]),
      .o_tick_next  (w_tick_next[i])
    );
  end

  // Built from next-state tick conditions so it lands in the tick cycle.
  always_ff @(posedge clk_amisha) begin
    if (!reset_amisha) begin
      r_any_tick <= 1'b0;
    end else begin
      r_any_tick <= |w_tick_next;
    end
  end

  assign any_tick_amisha = r_any_tick;

endmodule

// File: tb/tb_edge_detect_multi_amisha.sv
// Self-checking bench: table vectors, directed corner sequences and random
// stimulus against a window-based reference model of the debounced detector.
module tb_edge_detect_multi_amisha;

  localparam int CH     = 4;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] level;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] tick_o, rise_o, fall_o, filt_o;
  logic          any_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  edge_detect_multi_amisha #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (8)
  ) dut (
    .clk_amisha       (clk),
    .reset_amisha     (rst_n),
    .level_amisha     (level),
    .mode_amisha      (mode),
    .tick_amisha      (tick_o),
    .rise_amisha      (rise_o),
    .fall_amisha      (fall_o),
    .level_filt_amisha(filt_o),
    .any_tick_amisha  (any_o)
  );

  always #5 clk = ~clk;

  // Reference model: delay line for the synchroniser, and a sliding window of
  // the last STABLE synchronised samples; a full window of the opposite level
  // flips the filtered level.
  logic [CH-1:0] m_pipe [SYNC];
  logic [CH-1:0] m_hist [$];
  logic [CH-1:0] m_filt, m_rise, m_fall;
  logic          m_any;

  int first_rise [CH];
  int first_fall [CH];
  int first_fup  [CH];
  int first_fdn  [CH];
  int tick_cnt   [CH];
  int first_all, first_any, any_cnt;
  logic [CH-1:0] prev_filt = '0;

  function automatic void model_edge(input logic [CH-1:0] lvl, input logic [2*CH-1:0] md,
                                     input logic rst);
    logic [CH-1:0] s;
    logic acc;
    if (!rst) begin
      for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
      m_hist.delete();
      m_filt = '0;
      m_rise = '0;
      m_fall = '0;
      m_any  = 1'b0;
    end else begin
      s = m_pipe[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = lvl;
      m_hist.push_back(s);
      if (m_hist.size() > STABLE) void'(m_hist.pop_front());
      for (int ch = 0; ch < CH; ch++) begin
        acc = (m_hist.size() == STABLE);
        for (int k = 0; k < m_hist.size(); k++) begin
          if (m_hist[k][ch] == m_filt[ch]) acc = 1'b0;
        end
        m_rise[ch] = 1'b0;
        m_fall[ch] = 1'b0;
        if (acc) begin
          m_filt[ch] = ~m_filt[ch];
          if (m_filt[ch]) m_rise[ch] = md[2*ch];
          else            m_fall[ch] = md[2*ch+1];
        end
      end
      m_any = |(m_rise | m_fall);
    end
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic clr_stamps();
    for (int ch = 0; ch < CH; ch++) begin
      first_rise[ch] = -1;
      first_fall[ch] = -1;
      first_fup[ch]  = -1;
      first_fdn[ch]  = -1;
      tick_cnt[ch]   = 0;
    end
    first_all = -1;
    first_any = -1;
    any_cnt   = 0;
  endtask

  // One clock: drive inputs, take the edge, step the model, sample at +1.
  task automatic do_cycle(input logic [CH-1:0] lvl, input logic [2*CH-1:0] md, input logic rst);
    level = lvl;
    mode  = md;
    rst_n = rst;
    @(posedge clk);
    model_edge(lvl, md, rst);
    #1;
    cyc++;
    check("model", {tick_o, rise_o, fall_o, filt_o, any_o},
          {m_rise | m_fall, m_rise, m_fall, m_filt, m_any});
    for (int ch = 0; ch < CH; ch++) begin
      if (rise_o[ch] && first_rise[ch] < 0) first_rise[ch] = cyc;
      if (fall_o[ch] && first_fall[ch] < 0) first_fall[ch] = cyc;
      if (tick_o[ch]) tick_cnt[ch]++;
      if (filt_o[ch] && !prev_filt[ch] && first_fup[ch] < 0) first_fup[ch] = cyc;
      if (!filt_o[ch] && prev_filt[ch] && first_fdn[ch] < 0) first_fdn[ch] = cyc;
    end
    if (tick_o == 4'hF && first_all < 0) first_all = cyc;
    if (any_o) begin
      any_cnt++;
      if (first_any < 0) first_any = cyc;
    end
    prev_filt = filt_o;
  endtask

  task automatic run(input logic [CH-1:0] lvl, input logic [2*CH-1:0] md, input int n);
    for (int k = 0; k < n; k++) do_cycle(lvl, md, 1'b1);
  endtask

  typedef struct {
    logic [CH-1:0]   lvl;
    logic [2*CH-1:0] md;
    logic            rst;
    logic [16:0]     exp;  // {tick, rise, fall, level_filt, any}
  } vec_t;

  vec_t tbl [11];

  initial begin : main
    int start;
    int tsum;
    logic [CH-1:0]   rl;
    logic [2*CH-1:0] rm;
    logic            rr;

    clr_stamps();

    // Reset with all levels high, then the accepted rise after release.
    for (int i = 0; i < 3; i++)  tbl[i] = '{4'hF, 8'hFF, 1'b0, 17'h0};
    for (int i = 3; i < 8; i++)  tbl[i] = '{4'hF, 8'hFF, 1'b1, 17'h0};
    tbl[8] = '{4'hF, 8'hFF, 1'b1, {4'hF, 4'hF, 4'h0, 4'hF, 1'b1}};
    for (int i = 9; i < 11; i++) tbl[i] = '{4'hF, 8'hFF, 1'b1, {4'h0, 4'h0, 4'h0, 4'hF, 1'b0}};

    for (int i = 0; i < 11; i++) begin
      do_cycle(tbl[i].lvl, tbl[i].md, tbl[i].rst);
      check("table", {tick_o, rise_o, fall_o, filt_o, any_o}, tbl[i].exp);
    end
    run(4'h0, 8'hFF, 12);

    // ch0 rise-only: rise ticks at edge 6, fall only moves level_filt.
    clr_stamps(); start = cyc;
    run(4'h1, 8'h01, 10);
    check_int("ch0_rise_at", first_rise[0] - start, 6);
    check_int("ch0_filt_up_at", first_fup[0] - start, 6);
    check_int("ch0_rise_ticks", tick_cnt[0], 1);
    clr_stamps(); start = cyc;
    run(4'h0, 8'h01, 10);
    check_int("ch0_filt_dn_at", first_fdn[0] - start, 6);
    check_int("ch0_fall_ticks", tick_cnt[0], 0);

    // ch1 both: 3-cycle glitch rejected, 4-cycle pulse accepted.
    clr_stamps();
    run(4'h2, 8'h0C, 3);
    run(4'h0, 8'h0C, 10);
    check_int("ch1_glitch_ticks", tick_cnt[1], 0);
    check_int("ch1_glitch_filt", first_fup[1], -1);
    clr_stamps(); start = cyc;
    run(4'h2, 8'h0C, 4);
    run(4'h0, 8'h0C, 10);
    check_int("ch1_pulse_rise_at", first_rise[1] - start, 6);
    check_int("ch1_pulse_fall_at", first_fall[1] - start, 10);

    // ch2 fall-only.
    clr_stamps(); start = cyc;
    run(4'h4, 8'h20, 8);
    check_int("ch2_rise_ticks", tick_cnt[2], 0);
    check_int("ch2_filt_up_at", first_fup[2] - start, 6);
    clr_stamps(); start = cyc;
    run(4'h0, 8'h20, 8);
    check_int("ch2_fall_at", first_fall[2] - start, 6);
    check_int("ch2_fall_ticks", tick_cnt[2], 1);
    check_int("ch2_filt_dn_at", first_fdn[2] - start, 6);

    // Simultaneous rise on all channels, then mode changes with stable levels.
    clr_stamps(); start = cyc;
    run(4'hF, 8'hFF, 10);
    check_int("all_tick_at", first_all - start, 6);
    check_int("any_count", any_cnt, 1);
    check_int("any_aligned", first_any, first_all);
    clr_stamps();
    run(4'hF, 8'h00, 10);
    run(4'hF, 8'hFF, 5);
    run(4'h0, 8'h00, 10);
    run(4'h0, 8'hFF, 5);
    tsum = 0;
    for (int ch = 0; ch < CH; ch++) tsum += tick_cnt[ch];
    check_int("mode_change_ticks", tsum, 0);
    check_int("mode_change_any", any_cnt, 0);

    // ch3 rise interrupted by a one-cycle reset mid-debounce.
    clr_stamps();
    run(4'h8, 8'hC0, 3);
    do_cycle(4'h8, 8'hC0, 1'b0);
    start = cyc;
    check("rst_mid_outputs", {tick_o, rise_o, fall_o, filt_o, any_o}, 17'h0);
    run(4'h8, 8'hC0, 10);
    check_int("rst_mid_rise_at", first_rise[3] - start, 6);
    check_int("rst_mid_ticks", tick_cnt[3], 1);

    // Random levels, modes and occasional resets against the model.
    rl = 4'h8;
    rm = 8'hC0;
    for (int n = 0; n < 2000; n++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(5, 0) == 0) rl[ch] = ~rl[ch];
      end
      if ($urandom_range(19, 0) == 0) rm = 8'($urandom);
      rr = ($urandom_range(199, 0) != 0);
      do_cycle(rl, rm, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
